// File: rtl/thread_offset_table_if.sv
// Bundle between the offset table and its neighbours: address/config inputs, aligned offset-select outputs.
// Master drives decode and config; slave is the offset table.
interface thread_offset_table_if #(
  parameter int WORD_WIDTH        = 10,
  parameter int INCR_WIDTH        = 4,
  parameter int THREAD_ADDR_WIDTH = 3
);
  logic                         in_valid;
  logic [WORD_WIDTH-1:0]        addr_in;
  logic                         is_indirect;
  logic                         cfg_wren;
  logic [THREAD_ADDR_WIDTH-1:0] cfg_thread;
  logic [WORD_WIDTH-1:0]        cfg_offset;
  logic [INCR_WIDTH-1:0]        cfg_increment;
  logic [WORD_WIDTH-1:0]        addr_out;
  logic [WORD_WIDTH-1:0]        offset;
  logic                         use_raw_addr;
  logic                         valid_out;
  logic [THREAD_ADDR_WIDTH-1:0] thread_out;

  modport master (
    output in_valid, addr_in, is_indirect, cfg_wren, cfg_thread, cfg_offset, cfg_increment,
    input  addr_out, offset, use_raw_addr, valid_out, thread_out
  );

  modport slave (
    input  in_valid, addr_in, is_indirect, cfg_wren, cfg_thread, cfg_offset, cfg_increment,
    output addr_out, offset, use_raw_addr, valid_out, thread_out
  );
endinterface

// File: rtl/thread_offset_table.sv
// Round-robin per-thread offset table with post-increment on indirect accesses.
// Latency 1 cycle, all outputs aligned; no backpressure, never stalls.
module thread_offset_table #(
  parameter int WORD_WIDTH        = 10,
  parameter int INCR_WIDTH        = 4,
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3
) (
  input logic                   clock,
  input logic                   reset_n,
  thread_offset_table_if.slave  bus
);

  logic [THREAD_ADDR_WIDTH-1:0] r_thread;
  logic [WORD_WIDTH-1:0]        r_offset_mem [THREAD_COUNT];
  logic [INCR_WIDTH-1:0]        r_incr_mem   [THREAD_COUNT];

  logic [WORD_WIDTH-1:0]        r_addr_out;
  logic [WORD_WIDTH-1:0]        r_offset;
  logic                         r_use_raw_addr;
  logic                         r_valid_out;
  logic [THREAD_ADDR_WIDTH-1:0] r_thread_out;

  logic                         w_post_inc;
  logic [WORD_WIDTH-1:0]        w_cur_offset;
  logic [INCR_WIDTH-1:0]        w_cur_incr;
  logic [WORD_WIDTH-1:0]        w_incr_ext;
  logic [WORD_WIDTH-1:0]        w_next_offset;

  assign w_post_inc    = bus.in_valid & bus.is_indirect;
  assign w_cur_offset  = r_offset_mem[r_thread];
  assign w_cur_incr    = r_incr_mem[r_thread];
  assign w_incr_ext    = {{(WORD_WIDTH-INCR_WIDTH){w_cur_incr[INCR_WIDTH-1]}}, w_cur_incr};
  assign w_next_offset = w_cur_offset + w_incr_ext;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_thread <= '0;
    end else if (r_thread == THREAD_ADDR_WIDTH'(THREAD_COUNT-1)) begin
      r_thread <= '0;
    end else begin
      r_thread <= r_thread + THREAD_ADDR_WIDTH'(1);
    end
  end

  // Config beats post-increment on the same entry; a cfg_thread beyond the
  // table matches no entry and is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < THREAD_COUNT; i++) begin
        r_offset_mem[i] <= '0;
        r_incr_mem[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < THREAD_COUNT; i++) begin
        if (bus.cfg_wren && (bus.cfg_thread == THREAD_ADDR_WIDTH'(i))) begin
          r_offset_mem[i] <= bus.cfg_offset;
          r_incr_mem[i]   <= bus.cfg_increment;
        end else if (w_post_inc && (r_thread == THREAD_ADDR_WIDTH'(i))) begin
          r_offset_mem[i] <= w_next_offset;
        end
      end
    end
  end

  // Emitted offset is the pre-increment / pre-config value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr_out     <= '0;
      r_offset       <= '0;
      r_use_raw_addr <= 1'b1;
      r_valid_out    <= 1'b0;
      r_thread_out   <= '0;
    end else begin
      r_addr_out     <= bus.addr_in;
      r_offset       <= w_cur_offset;
      r_use_raw_addr <= ~w_post_inc;
      r_valid_out    <= bus.in_valid;
      r_thread_out   <= r_thread;
    end
  end

  assign bus.addr_out     = r_addr_out;
  assign bus.offset       = r_offset;
  assign bus.use_raw_addr = r_use_raw_addr;
  assign bus.valid_out    = r_valid_out;
  assign bus.thread_out   = r_thread_out;

endmodule

// File: doc/thread_offset_table.md
# thread_offset_table

Per-thread offset generator with post-increment for indirect addressing, placed directly upstream of the offset selector stage. Each hardware thread owns one offset register and one signed increment register. Threads are visited in fixed round-robin order, one per cycle. On the current thread's slot, the block emits that thread's current offset and a raw/offset select, time-aligned with the incoming address. It then post-increments the offset if the access was indirect.

## Interface
Parameters:
- WORD_WIDTH, 10, width of addresses and offsets
- INCR_WIDTH, 4, width of signed per-thread increment
- THREAD_COUNT, 8, number of round-robin threads (>=1)
- THREAD_ADDR_WIDTH, 3, ceil(log2(THREAD_COUNT)), minimum 1

Ports:
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  an address is presented this cycle
- addr_in  in  WORD_WIDTH  raw address from instruction decode
- is_indirect  in  1  address falls in the indirect window
- cfg_wren  in  1  write offset/increment for cfg_thread
- cfg_thread  in  THREAD_ADDR_WIDTH  thread being configured
- cfg_offset  in  WORD_WIDTH  new offset value
- cfg_increment  in  INCR_WIDTH  new signed increment
- addr_out  out  WORD_WIDTH  registered copy of addr_in
- offset  out  WORD_WIDTH  offset for addr_out's thread
- use_raw_addr  out  1  1 = selector passes raw address
- valid_out  out  1  registered in_valid
- thread_out  out  THREAD_ADDR_WIDTH  thread owning current outputs

## Operation
- Internal thread counter `thread`:
  - 0 after reset.
  - Increments every cycle regardless of in_valid.
  - Wraps from THREAD_COUNT-1 to 0.
- State:
  - offset_mem[THREAD_COUNT] of WORD_WIDTH.
  - incr_mem[THREAD_COUNT] of INCR_WIDTH.
  - Both are flops, not RAM.
- Each cycle, with t = thread:
  - Outputs register: addr_out<=addr_in, offset<=offset_mem[t], use_raw_addr<=~(in_valid & is_indirect), valid_out<=in_valid, thread_out<=t.
  - If in_valid & is_indirect: offset_mem[t] <= offset_mem[t] + sign_extend(incr_mem[t]).
- Arithmetic:
  - Two's complement, modulo 2^WORD_WIDTH.
  - Wrap-around is silent; no saturation and no flag.
- Post-increment semantics: the emitted offset is the pre-increment value.
- Config write (cfg_wren=1):
  - offset_mem[cfg_thread]<=cfg_offset and incr_mem[cfg_thread]<=cfg_increment.
  - cfg_thread >= THREAD_COUNT: the write is ignored.
- Simultaneous events:
  - Config write and post-increment on the same thread, same cycle: the config write wins; the increment is dropped.
  - Config write to thread t while t is being read: the output shows the old offset (read-before-write).
  - Config write to a different thread: both updates take effect.
- in_valid=0: no increment; use_raw_addr=1; offset still driven from the table.
- Reset (asynchronous, including mid-operation):
  - Clears thread counter, all offset_mem and incr_mem entries, addr_out, offset, valid_out and thread_out to 0.
  - Sets use_raw_addr to 1.
  - Counting resumes at thread 0 on the first edge after release.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N, all outputs aligned to the same access.
- The downstream selector registers these outputs, so the selected address appears 2 cycles after its own registration.
- An incremented offset is visible at the same thread's next slot, THREAD_COUNT cycles later. With THREAD_COUNT=1, that is the next cycle.
- A config write at edge N is visible on the target thread's first slot after edge N.
- No handshake or backpressure; the block never stalls.

## Test plan
- Reset, then hold in_valid=0 for 16 cycles -> thread_out counts 0..7,0..7; offset=0, use_raw_addr=1, valid_out=0 throughout.
- Config thread 2 offset=100, increment=+4; send indirect accesses on thread 2's slots, 3 times -> offset outputs 100, 104, 108; other threads stay at 0.
- Config thread 5 offset=2, increment=-3 (4'b1101); 2 indirect accesses -> offsets 2, 1023 (wrap at WORD_WIDTH=10).
- Config write to thread 3 (offset=50) in the same cycle as a thread-3 indirect access with old offset 10, increment 1 -> output offset 10; next thread-3 slot shows 50, not 51.
- Direct access (is_indirect=0, in_valid=1) on thread 1 with offset 7 -> use_raw_addr=1, addr_out=addr_in; offset stays 7 at the next slot.
- Assert reset_n low mid-stream after several increments -> all outputs 0 and use_raw_addr=1 immediately (asynchronous); after release, thread_out restarts at 0 and all offsets read 0.
